// File: rtl/vid_mem_arb_pkg.sv
// Shared definitions for the video memory arbiter.
// Holds the controller state encoding, the requester index constants and
// the default parameter values used by vid_mem_arbiter and its sub-module.
package vid_mem_arb_pkg;

    localparam int DEF_ADDR_BITS  = 24;
    localparam int DEF_DATA_BITS  = 16;
    localparam int DEF_BURST_BITS = 8;
    localparam int DEF_MAX_FB     = 4;

    localparam int NUM_REQ = 3;

    // Requester indices
    localparam logic [1:0] FB   = 2'd0;  // framebuffer read
    localparam logic [1:0] MIPI = 2'd1;  // MIPI write
    localparam logic [1:0] CPU  = 2'd2;  // CPU

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_CMD  = 2'd1,
        RD_DATA = 2'd2,
        WR_DATA = 2'd3
    } arb_state_t;

endpackage

// File: rtl/vid_mem_arb_pick.sv
// Winner selection for the video memory arbiter (purely combinational).
// Ports:
//   req      in  3  per-requester request
//   fb_full  in  1  fairness counter has reached its limit
//   rr_cpu   in  1  round-robin pointer: 0 = MIPI next, 1 = CPU next
//   valid    out 1  at least one requester is asking
//   idx      out 2  index of the winning requester
module vid_mem_arb_pick
    import vid_mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               fb_full,
    input  logic               rr_cpu,
    output logic               valid,
    output logic [1:0]         idx
);

    logic others;

    always_comb begin
        valid  = |req;
        others = req[MIPI] | req[CPU];
        idx    = FB;
        // Framebuffer has priority until it has starved the others long enough.
        if (req[FB] && !(fb_full && others)) begin
            idx = FB;
        end else if (rr_cpu) begin
            idx = req[CPU] ? CPU : MIPI;
        end else begin
            idx = req[MIPI] ? MIPI : CPU;
        end
    end

endmodule

// File: rtl/vid_mem_arbiter.sv
// Three-way Avalon-MM burst arbiter for the video SDRAM port.
// Requester 0 (framebuffer) has priority, bounded by a fairness counter;
// requesters 1 (MIPI) and 2 (CPU) share the rest round-robin. One
// transaction runs at a time and each is followed by one IDLE cycle.
// Ports:
//   iCLK / iRESET            clock, synchronous active-high reset
//   iREQ/iWR/iADDR/iBURST    per-requester request, direction, address, beats
//   iWDATA                   per-requester write word
//   oGNT                     one-hot grant held for the transaction
//   oWDATA_ACK               write word consumed this cycle
//   oRDATA / oRDATA_VALID    read word and per-requester beat strobe
//   oAV_*  / iAV_*           Avalon master side
//   oBUSY                    controller not in IDLE
module vid_mem_arbiter
    import vid_mem_arb_pkg::*;
#(
    parameter int pADDR_BITS  = DEF_ADDR_BITS,
    parameter int pDATA_BITS  = DEF_DATA_BITS,
    parameter int pBURST_BITS = DEF_BURST_BITS,
    parameter int pMAX_FB     = DEF_MAX_FB
) (
    input  logic                            iCLK,
    input  logic                            iRESET,
    input  logic [NUM_REQ-1:0]              iREQ,
    input  logic [NUM_REQ-1:0]              iWR,
    input  logic [NUM_REQ*pADDR_BITS-1:0]   iADDR,
    input  logic [NUM_REQ*pBURST_BITS-1:0]  iBURST,
    input  logic [NUM_REQ*pDATA_BITS-1:0]   iWDATA,
    output logic [NUM_REQ-1:0]              oGNT,
    output logic [NUM_REQ-1:0]              oWDATA_ACK,
    output logic [pDATA_BITS-1:0]           oRDATA,
    output logic [NUM_REQ-1:0]              oRDATA_VALID,
    output logic [pADDR_BITS-1:0]           oAV_ADDRESS,
    output logic                            oAV_READ,
    output logic                            oAV_WRITE,
    output logic [pBURST_BITS-1:0]          oAV_BURSTCOUNT,
    output logic [pDATA_BITS-1:0]           oAV_WRITEDATA,
    input  logic                            iAV_WAITREQUEST,
    input  logic [pDATA_BITS-1:0]           iAV_READDATA,
    input  logic                            iAV_READDATAVALID,
    output logic                            oBUSY
);

    localparam int FB_W = (pMAX_FB < 1) ? 1 : $clog2(pMAX_FB + 1);

    arb_state_t             state, state_nxt;
    logic [NUM_REQ-1:0]     gnt;
    logic [1:0]             gnt_idx;
    logic [pADDR_BITS-1:0]  addr_q;
    logic [pBURST_BITS-1:0] burst_q;
    logic [pBURST_BITS-1:0] beat_cnt;
    logic [FB_W-1:0]        fb_cnt;
    logic                   rr_cpu;

    logic                   pick_valid;
    logic [1:0]             pick_idx;
    logic                   pick_wr;
    logic [pADDR_BITS-1:0]  pick_addr;
    logic [pBURST_BITS-1:0] pick_burst;
    logic                   fb_full;
    logic                   others_req;
    logic                   beat;
    logic                   last_beat;
    int                     pick_sel;
    int                     gnt_sel;

    // Counter saturates at pMAX_FB, so equality is the "reached" test.
    assign fb_full    = (fb_cnt == FB_W'(pMAX_FB));
    assign others_req = iREQ[MIPI] | iREQ[CPU];

    vid_mem_arb_pick u_pick (
        .req     (iREQ),
        .fb_full (fb_full),
        .rr_cpu  (rr_cpu),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    assign pick_sel   = int'(pick_idx);
    assign gnt_sel    = int'(gnt_idx);
    assign pick_wr    = iWR[pick_idx];
    assign pick_addr  = iADDR[pick_sel*pADDR_BITS +: pADDR_BITS];
    assign pick_burst = iBURST[pick_sel*pBURST_BITS +: pBURST_BITS];

    // A beat is a read word delivered in RD_DATA or a write word accepted in WR_DATA.
    assign beat      = ((state == RD_DATA) && iAV_READDATAVALID) ||
                       ((state == WR_DATA) && !iAV_WAITREQUEST);
    assign last_beat = beat && (beat_cnt == burst_q - pBURST_BITS'(1));

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_idx  <= FB;
            addr_q   <= '0;
            burst_q  <= '0;
            beat_cnt <= '0;
            fb_cnt   <= '0;
            rr_cpu   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                beat_cnt <= '0;
                if (pick_valid) begin
                    gnt     <= 3'b001 << pick_idx;
                    gnt_idx <= pick_idx;
                    addr_q  <= pick_addr;
                    burst_q <= (pick_burst == '0) ? pBURST_BITS'(1) : pick_burst;
                    if (pick_idx != FB) begin
                        fb_cnt <= '0;
                        rr_cpu <= (pick_idx == MIPI);
                    end else if (!others_req) begin
                        fb_cnt <= '0;
                    end else if (!fb_full) begin
                        fb_cnt <= fb_cnt + FB_W'(1);
                    end
                end
            end else begin
                if (beat) beat_cnt <= beat_cnt + pBURST_BITS'(1);
                if (state_nxt == IDLE) gnt <= '0;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        oAV_READ       = 1'b0;
        oAV_WRITE      = 1'b0;
        oAV_ADDRESS    = '0;
        oAV_BURSTCOUNT = '0;
        oAV_WRITEDATA  = '0;
        oRDATA         = '0;
        oRDATA_VALID   = '0;
        oWDATA_ACK     = '0;
        case (state)
            IDLE: begin
                if (pick_valid) state_nxt = pick_wr ? WR_DATA : RD_CMD;
            end
            RD_CMD: begin
                oAV_READ       = 1'b1;
                oAV_ADDRESS    = addr_q;
                oAV_BURSTCOUNT = burst_q;
                if (!iAV_WAITREQUEST) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                oAV_ADDRESS    = addr_q;
                oAV_BURSTCOUNT = burst_q;
                oRDATA         = iAV_READDATA;
                oRDATA_VALID   = iAV_READDATAVALID ? gnt : '0;
                if (last_beat) state_nxt = IDLE;
            end
            WR_DATA: begin
                oAV_WRITE      = 1'b1;
                oAV_ADDRESS    = addr_q;
                oAV_BURSTCOUNT = burst_q;
                oAV_WRITEDATA  = iWDATA[gnt_sel*pDATA_BITS +: pDATA_BITS];
                oWDATA_ACK     = iAV_WAITREQUEST ? '0 : gnt;
                if (last_beat) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign oGNT  = gnt;
    assign oBUSY = (state != IDLE);

endmodule

// File: tb/tb_vid_mem_arbiter.sv
// Self-checking bench for vid_mem_arbiter: directed vector table, reset
// mid-burst, fairness sequence and randomized traffic against a
// transaction-level model of the arbitration rules.
module tb_vid_mem_arbiter;

    localparam int AW = 24, DW = 16, BW = 8, MAXFB = 4;

    logic              iCLK = 1'b0;
    logic              iRESET;
    logic [2:0]        iREQ, iWR;
    logic [3*AW-1:0]   iADDR;
    logic [3*BW-1:0]   iBURST;
    logic [3*DW-1:0]   iWDATA;
    logic [2:0]        oGNT, oWDATA_ACK, oRDATA_VALID;
    logic [DW-1:0]     oRDATA, oAV_WRITEDATA, iAV_READDATA;
    logic [AW-1:0]     oAV_ADDRESS;
    logic              oAV_READ, oAV_WRITE, oBUSY;
    logic [BW-1:0]     oAV_BURSTCOUNT;
    logic              iAV_WAITREQUEST, iAV_READDATAVALID;

    always #5 iCLK = ~iCLK;

    vid_mem_arbiter #(.pADDR_BITS(AW), .pDATA_BITS(DW), .pBURST_BITS(BW), .pMAX_FB(MAXFB)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iREQ(iREQ), .iWR(iWR), .iADDR(iADDR),
        .iBURST(iBURST), .iWDATA(iWDATA), .oGNT(oGNT), .oWDATA_ACK(oWDATA_ACK),
        .oRDATA(oRDATA), .oRDATA_VALID(oRDATA_VALID), .oAV_ADDRESS(oAV_ADDRESS),
        .oAV_READ(oAV_READ), .oAV_WRITE(oAV_WRITE), .oAV_BURSTCOUNT(oAV_BURSTCOUNT),
        .oAV_WRITEDATA(oAV_WRITEDATA), .iAV_WAITREQUEST(iAV_WAITREQUEST),
        .iAV_READDATA(iAV_READDATA), .iAV_READDATAVALID(iAV_READDATAVALID), .oBUSY(oBUSY)
    );

    int       errors = 0, checks = 0;
    int       pend = 0;          // read beats the slave still owes
    int       wait_mode = 0;     // 0 none, 1 random, 2 stall beats 2 and 3
    bit       allow_spur = 0;    // inject stray readdatavalid
    int       wbeats = 0;
    bit [3:0] stall_done;
    int       m_fb = 0, m_next = 1;  // arbitration model state

    typedef struct {
        logic [2:0]    req;
        logic [2:0]    wr;
        logic [BW-1:0] burst;
        logic [AW-1:0] addr;
        int            mode;
        int            exp_idx;
        int            exp_beats;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock: drive slave/data inputs after the edge, return at negedge.
    task automatic tick();
        @(posedge iCLK); #1;
        for (int i = 0; i < 3; i++) iWDATA[i*DW +: DW] = DW'($urandom);
        case (wait_mode)
            0: iAV_WAITREQUEST = 1'b0;
            1: iAV_WAITREQUEST = ($urandom % 3 == 0);
            default: begin
                if ((wbeats == 1 || wbeats == 2) && !stall_done[wbeats]) begin
                    iAV_WAITREQUEST = 1'b1;
                    stall_done[wbeats] = 1'b1;
                end else iAV_WAITREQUEST = 1'b0;
            end
        endcase
        if (pend > 0) begin
            iAV_READDATAVALID = (wait_mode == 0) ? 1'b1 : ($urandom % 4 != 0);
            if (iAV_READDATAVALID) pend--;
        end else begin
            iAV_READDATAVALID = allow_spur && ($urandom % 3 == 0);
        end
        iAV_READDATA = DW'($urandom);
        @(negedge iCLK);
    endtask

    // Arbitration rules stated directly: FB first unless it has starved the
    // others MAXFB times in a row; otherwise alternate MIPI/CPU.
    task automatic ref_pick(input logic [2:0] req, output int win);
        bit others;
        others = req[1] | req[2];
        if (req[0] && !(others && m_fb >= MAXFB)) win = 0;
        else win = req[m_next] ? m_next : 3 - m_next;
        if (win == 0) m_fb = others ? ((m_fb < MAXFB) ? m_fb + 1 : MAXFB) : 0;
        else begin
            m_fb   = 0;
            m_next = (win == 1) ? 2 : 1;
        end
    endtask

    // Called at negedge of an IDLE cycle with iREQ already set. Checks grant,
    // bus behaviour and beat count, then returns at negedge of the next IDLE cycle.
    task automatic run_txn(input int exp_idx, input int exp_beats, input logic [2:0] nreq);
        logic [2:0]    oh;
        logic          exp_wr;
        logic [AW-1:0] exp_addr;
        int lat, beats, guard, bad_gnt, bad_bus, bad_strobe, overrun;
        bit cmd_acc;
        oh         = 3'b001 << exp_idx;
        exp_wr     = iWR[exp_idx];
        exp_addr   = iADDR[exp_idx*AW +: AW];
        allow_spur = exp_wr;
        wbeats     = 0;
        stall_done = '0;
        lat = 0;
        do begin tick(); lat++; end while (oGNT == 3'b000 && lat < 20);
        chk("grant", oGNT, oh);
        chk("grant_latency", lat, 1);
        if (oGNT == 3'b000) return;
        iREQ = nreq;
        beats = 0; guard = 0; cmd_acc = 0;
        bad_gnt = 0; bad_bus = 0; bad_strobe = 0; overrun = 0;
        while (oBUSY && guard < 400) begin
            if (oGNT !== oh) bad_gnt++;
            if (beats >= exp_beats) overrun++;
            if (exp_wr) begin
                if (!oAV_WRITE || oAV_READ || oAV_ADDRESS !== exp_addr ||
                    oAV_BURSTCOUNT !== BW'(exp_beats) ||
                    oAV_WRITEDATA !== iWDATA[exp_idx*DW +: DW]) bad_bus++;
                if (oWDATA_ACK !== (iAV_WAITREQUEST ? 3'b000 : oh) || oRDATA_VALID !== 3'b000) bad_strobe++;
                if (!iAV_WAITREQUEST) beats++;
                wbeats = beats;
            end else begin
                if (oAV_WRITE || oAV_READ !== !cmd_acc) bad_bus++;
                if (!cmd_acc && (oAV_ADDRESS !== exp_addr || oAV_BURSTCOUNT !== BW'(exp_beats))) bad_bus++;
                if (oRDATA_VALID !== (iAV_READDATAVALID ? oh : 3'b000) || oWDATA_ACK !== 3'b000 ||
                    (iAV_READDATAVALID && oRDATA !== iAV_READDATA)) bad_strobe++;
                if (cmd_acc && iAV_READDATAVALID) beats++;
                if (!cmd_acc && !iAV_WAITREQUEST) begin
                    cmd_acc = 1;
                    pend    = exp_beats;
                end
            end
            tick();
            guard++;
        end
        chk("beats", beats, exp_beats);
        chk("overrun", overrun, 0);
        chk("grant_held", bad_gnt, 0);
        chk("avalon_bus", bad_bus, 0);
        chk("strobes", bad_strobe, 0);
        chk("idle_outputs", {oGNT, oAV_READ, oAV_WRITE, oRDATA_VALID, oWDATA_ACK, oBUSY}, 12'h0);
        pend = 0;
    endtask

    task automatic do_reset();
        iREQ = 3'b000;
        iRESET = 1'b1;
        repeat (2) tick();
        iRESET = 1'b0;
        pend = 0; allow_spur = 0;
        m_fb = 0; m_next = 1;
    endtask

    initial begin
        vec_t vt[7];
        int   order[10];
        int   idx, b, rv, guard, bad;
        logic [2:0] nreq;

        iRESET = 1'b1; iREQ = '0; iWR = '0; iADDR = '0; iBURST = '0; iWDATA = '0;
        iAV_WAITREQUEST = 1'b0; iAV_READDATA = '0; iAV_READDATAVALID = 1'b0;
        repeat (3) tick();
        chk("rst_gnt",    oGNT, 3'b000);
        chk("rst_ack",    oWDATA_ACK, 3'b000);
        chk("rst_rvalid", oRDATA_VALID, 3'b000);
        chk("rst_read",   oAV_READ, 1'b0);
        chk("rst_write",  oAV_WRITE, 1'b0);
        chk("rst_busy",   oBUSY, 1'b0);
        iRESET = 1'b0;

        // Directed vectors; every request is withdrawn right after its grant.
        vt[0] = '{3'b001, 3'b000, 8'd8, 24'h000100, 0, 0, 8};  // FB read
        vt[1] = '{3'b010, 3'b010, 8'd4, 24'h002000, 2, 1, 4};  // MIPI write, stalls
        vt[2] = '{3'b100, 3'b000, 8'd0, 24'h003000, 1, 2, 1};  // burst 0 -> 1
        vt[3] = '{3'b110, 3'b110, 8'd3, 24'h004000, 1, 1, 3};  // rr back to MIPI
        vt[4] = '{3'b101, 3'b001, 8'd5, 24'h005000, 1, 0, 5};  // FB write wins
        vt[5] = '{3'b011, 3'b010, 8'd2, 24'h006000, 1, 0, 2};  // FB read wins
        vt[6] = '{3'b110, 3'b000, 8'd6, 24'h007000, 1, 2, 6};  // rr now on CPU
        for (int k = 0; k < 7; k++) begin
            iREQ = vt[k].req;
            iWR  = vt[k].wr;
            for (int i = 0; i < 3; i++) begin
                iADDR[i*AW +: AW]  = vt[k].addr + AW'(i * 'h10);
                iBURST[i*BW +: BW] = vt[k].burst;
            end
            wait_mode = vt[k].mode;
            run_txn(vt[k].exp_idx, vt[k].exp_beats, 3'b000);
        end

        // Reset in the middle of an 8-beat read.
        wait_mode = 0;
        iREQ = 3'b001; iWR = 3'b000; iBURST[0 +: BW] = 8'd8;
        guard = 0;
        do begin tick(); guard++; end while (oGNT == 3'b000 && guard < 20);
        iREQ = 3'b000;
        rv = 0;
        while (rv < 3 && guard < 60) begin
            if (oRDATA_VALID[0]) rv++;
            if (oAV_READ && !iAV_WAITREQUEST) pend = 8;
            if (rv < 3) tick();
            guard++;
        end
        chk("midread_beats", rv, 3);
        iRESET = 1'b1;
        tick();
        iRESET = 1'b0;
        chk("midread_reset_outputs",
            {oGNT, oAV_READ, oAV_WRITE, oRDATA_VALID, oWDATA_ACK, oBUSY}, 12'h0);
        bad = 0;
        repeat (3) begin
            tick();
            if (oRDATA_VALID !== 3'b000 || oBUSY) bad++;
        end
        chk("trailing_rvalid", bad, 0);
        pend = 0;

        // All three requesting continuously: fairness pattern.
        order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2};
        iREQ = 3'b111;
        for (int k = 0; k < 20; k++) begin
            iWR = 3'($urandom);
            b = $urandom_range(1, 3);
            for (int i = 0; i < 3; i++) begin
                iADDR[i*AW +: AW]  = AW'($urandom);
                iBURST[i*BW +: BW] = BW'(b);
            end
            wait_mode = 1;
            run_txn(order[k % 10], b, 3'b111);
        end

        // Randomized traffic against the model.
        do_reset();
        iREQ = 3'($urandom_range(1, 7));
        for (int k = 0; k < 40; k++) begin
            iWR = 3'($urandom);
            for (int i = 0; i < 3; i++) begin
                iADDR[i*AW +: AW]  = AW'($urandom);
                iBURST[i*BW +: BW] = BW'($urandom_range(0, 5));
            end
            wait_mode = 1;
            ref_pick(iREQ, idx);
            b = int'(iBURST[idx*BW +: BW]);
            nreq = 3'($urandom_range(1, 7));
            run_txn(idx, (b == 0) ? 1 : b, nreq);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vid_mem_arbiter.md
VID_MEM_ARBITER -- requirements
Module: vid_mem_arbiter

Interface
REQ-001 SHALL have parameter pADDR_BITS, default 24, SDRAM word address width.
REQ-002 SHALL have parameter pDATA_BITS, default 16, data word width.
REQ-003 SHALL have parameter pBURST_BITS, default 8, burst-length field width.
REQ-004 SHALL have parameter pMAX_FB, default 4, maximum consecutive requester-0 grants while others wait.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have the following ports:
- iCLK  in  1  system clock, wMEM_CLK domain.
- iRESET  in  1  synchronous active-high reset.
- iREQ  in  3  per-requester request (0 = framebuffer read, 1 = MIPI write, 2 = CPU).
- iWR  in  3  per-requester direction (1 = write).
- iADDR  in  3*pADDR_BITS  per-requester start address.
- iBURST  in  3*pBURST_BITS  per-requester beat count.
- iWDATA  in  3*pDATA_BITS  per-requester write word.
- oGNT  out  3  one-hot grant, held for the whole transaction.
- oWDATA_ACK  out  3  pulse: current write word consumed.
- oRDATA  out  pDATA_BITS  read word, shared by all requesters.
- oRDATA_VALID  out  3  per-requester read beat strobe.
- oAV_ADDRESS  out  pADDR_BITS  Avalon master address.
- oAV_READ  out  1  Avalon master read.
- oAV_WRITE  out  1  Avalon master write.
- oAV_BURSTCOUNT  out  pBURST_BITS  Avalon master burst count.
- oAV_WRITEDATA  out  pDATA_BITS  Avalon master write data.
- iAV_WAITREQUEST  in  1  slave stall.
- iAV_READDATA  in  pDATA_BITS  slave read data.
- iAV_READDATAVALID  in  1  slave read beat valid.
- oBUSY  out  1  high in any state except IDLE.

Function
REQ-007 SHALL implement the states IDLE, RD_CMD, RD_DATA and WR_DATA.
REQ-008 SHALL sample iREQ only in IDLE, assert oGNT on the following cycle, and latch iWR, iADDR and iBURST of the winner at that point.
REQ-009 SHALL select the winner as follows:
- Requester 0 wins if requesting, unless the fairness counter has reached pMAX_FB while requester 1 or 2 is requesting.
- Otherwise requesters 1 and 2 are served round-robin, starting with 1 after reset.
REQ-010 SHALL clear the fairness counter on any grant to requester 1 or 2, or when requester 0 is granted with no other request pending; it saturates at pMAX_FB.
REQ-011 SHALL coerce a latched burst of 0 to 1.
REQ-012 SHALL, in RD_CMD, hold oAV_READ, oAV_ADDRESS and oAV_BURSTCOUNT until a cycle with iAV_WAITREQUEST=0, then go to RD_DATA.
REQ-013 SHALL, in RD_DATA, pass iAV_READDATA to oRDATA and iAV_READDATAVALID to oRDATA_VALID[grant] combinationally, count beats, and return to IDLE after the last beat.
REQ-014 SHALL, in WR_DATA, drive oAV_WRITE with oAV_WRITEDATA = iWDATA[grant] and the address/burstcount held constant for the whole burst.
REQ-015 SHALL treat a write beat as accepted when oAV_WRITE=1 and iAV_WAITREQUEST=0, pulse oWDATA_ACK[grant] in that same cycle, and return to IDLE after the last beat.
REQ-016 SHALL ignore iREQ deassertion mid-transaction; the burst always completes.
REQ-017 SHALL spend exactly one IDLE cycle between consecutive transactions.
REQ-018 SHALL discard iAV_READDATAVALID while in IDLE or WR_DATA (oRDATA_VALID stays 0).
REQ-019 SHALL drive oAV_READ and oAV_WRITE to 0 in IDLE.

Reset
REQ-020 SHALL, on iRESET, enter IDLE from any state, including mid-burst.
REQ-021 SHALL reset oGNT, oWDATA_ACK, oRDATA_VALID, oAV_READ, oAV_WRITE and oBUSY to 0.
REQ-022 SHALL reset the beat counter and fairness counter to 0 and the round-robin pointer to requester 1.

Structure
REQ-023 SHALL place the state enum, requester index constants (FB=0, MIPI=1, CPU=2) and the default parameter values in package vid_mem_arb_pkg.
REQ-024 SHALL implement the winner selection of REQ-009 in the combinational sub-module vid_mem_arb_pick.

Verification
REQ-025 Single FB read: iREQ=001, iADDR[0]=0x000100, burst 8, waitrequest 0 -> oGNT=001 one cycle later; 8 oRDATA_VALID[0] pulses; return to IDLE after the 8th beat.
REQ-026 MIPI write, burst 4, iAV_WAITREQUEST high on beats 2-3 -> exactly 4 oWDATA_ACK[1] pulses, each aligned with waitrequest=0; addr and burstcount constant throughout.
REQ-027 iREQ=111 held continuously, pMAX_FB=4 -> grant order 0,0,0,0,1,0,0,0,0,2 repeating.
REQ-028 Burst 0 CPU read -> oAV_BURSTCOUNT=1, one oRDATA_VALID[2] beat.
REQ-029 iRESET mid-read at beat 3 of 8 -> next cycle IDLE with all outputs 0; trailing readdatavalid beats produce no oRDATA_VALID.
REQ-030 iREQ[1] dropped after grant -> burst still completes its full beat count.
